// File: rtl/dcache_write_buffer.sv
// Posted write buffer between the data cache and data memory: writebacks are
// absorbed into a small FIFO and drained in the background, reads bypass queued writes.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no memory request outstanding; picks the next read or drain
// DRAIN | mem_write held for the head entry until memory completes
// MREAD | mem_read held for the pending cache read miss
module dcache_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     cache_read,
    input  logic                     cache_write,
    input  logic [ADDR_W-1:0]        cache_address,
    input  logic [DATA_W-1:0]        cache_writedata,
    output logic [DATA_W-1:0]        cache_readdata,
    output logic                     cache_busywait,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [DATA_W-1:0]        mem_writedata,
    input  logic [DATA_W-1:0]        mem_readdata,
    input  logic                     mem_busywait,
    output logic                     wb_empty,
    output logic [$clog2(DEPTH):0]   wb_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, MREAD} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [PTR_W:0]      count;
    logic                ack;
    logic                read_active;

    logic                fwd_hit;
    logic [DATA_W-1:0]   fwd_data;
    logic                read_req;
    logic                hit_now;
    logic                miss_now;
    logic                pop;
    logic                push;

    // Scan oldest to youngest so the last match (youngest write) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PTR_W+1)'(i) < count && addr_q[head + PTR_W'(i)] == cache_address) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[head + PTR_W'(i)];
            end
        end
    end

    assign read_req = cache_read & ~ack;
    assign hit_now  = read_req & ~read_active & fwd_hit;
    assign miss_now = read_req & ~read_active & ~fwd_hit;
    assign pop      = (state == DRAIN) & ~mem_busywait;
    // A slot freed by a pop on this edge can be refilled on the same edge.
    assign push     = cache_write & ~cache_read & ~ack & ((count != FULL) | pop);

    assign cache_busywait = (cache_read | cache_write) & ~ack & ~RESET;
    assign wb_empty       = (count == '0);
    assign wb_count       = count;

    always_ff @(posedge CLK) begin
        if (push) begin
            addr_q[tail] <= cache_address;
            data_q[tail] <= cache_writedata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= IDLE;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            ack            <= 1'b0;
            read_active    <= 1'b0;
            cache_readdata <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_writedata  <= '0;
        end else begin
            ack <= 1'b0;
            if (hit_now) begin
                cache_readdata <= fwd_data;
                ack            <= 1'b1;
            end
            if (push) begin
                tail <= tail + 1'b1;
                ack  <= 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (miss_now) begin
                read_active <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (read_active | miss_now) begin
                        state       <= MREAD;
                        mem_read    <= 1'b1;
                        mem_address <= cache_address;
                    end else if (count != '0) begin
                        state         <= DRAIN;
                        mem_write     <= 1'b1;
                        mem_address   <= addr_q[head];
                        mem_writedata <= data_q[head];
                    end
                end
                DRAIN: begin
                    if (!mem_busywait) begin
                        mem_write <= 1'b0;
                        state     <= IDLE;
                    end
                end
                MREAD: begin
                    if (!mem_busywait) begin
                        mem_read       <= 1'b0;
                        cache_readdata <= mem_readdata;
                        ack            <= 1'b1;
                        read_active    <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Bench for dcache_write_buffer: directed scenarios plus random traffic checked
// against a coherent-memory view and an in-order queue of expected memory writes.
module tb_dcache_write_buffer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        cache_read, cache_write;
    logic [5:0]  cache_address;
    logic [31:0] cache_writedata;
    logic [31:0] cache_readdata;
    logic        cache_busywait;
    logic        mem_read, mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
    logic        wb_empty;
    logic [2:0]  wb_count;

    int vectors = 0;
    int miscompares = 0;

    // memory device model
    logic [31:0] mem_arr [64];
    int          lat = 1;
    bit          hold = 0;
    int          lat_cnt = 0;
    bit          mem_read_seen = 0;
    logic [6:0]  ops_log [$];

    // reference: coherent view of memory and writes still owed to memory
    logic [31:0] shadow [64];
    logic [37:0] exp_q [$];

    dcache_write_buffer #(.DEPTH(4), .ADDR_W(6), .DATA_W(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .cache_read(cache_read), .cache_write(cache_write),
        .cache_address(cache_address), .cache_writedata(cache_writedata),
        .cache_readdata(cache_readdata), .cache_busywait(cache_busywait),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
        .wb_empty(wb_empty), .wb_count(wb_count)
    );

    always #5 CLK = ~CLK;

    assign mem_busywait = (mem_read || mem_write) && (hold || lat_cnt < lat);
    assign mem_readdata = mem_arr[mem_address];

    always @(posedge CLK) begin
        logic [37:0] e;
        if (RESET || !(mem_read || mem_write)) begin
            lat_cnt <= 0;
        end else if (mem_busywait) begin
            lat_cnt <= lat_cnt + 1;
        end else begin
            lat_cnt <= 0;
            ops_log.push_back({mem_read, mem_address});
            if (mem_write) begin
                mem_arr[mem_address] <= mem_writedata;
                vectors++;
                if (exp_q.size() == 0) begin
                    $display("FAIL mem_write_order: got %h/%h, required no write", mem_address, mem_writedata);
                    miscompares++;
                end else begin
                    e = exp_q.pop_front();
                    if ({mem_address, mem_writedata} !== e) begin
                        $display("FAIL mem_write_order: got %h/%h, required %h/%h",
                                 mem_address, mem_writedata, e[37:32], e[31:0]);
                        miscompares++;
                    end
                end
            end
        end
        if (!RESET && mem_read) mem_read_seen = 1;
    end

    always @(negedge CLK) begin
        if (RESET === 1'b0) begin
            vectors++;
            if (mem_read && mem_write) begin
                $display("FAIL mem_exclusive: mem_read=%b mem_write=%b, required not both", mem_read, mem_write);
                miscompares++;
            end
        end
    end

    // Called at a negedge; returns at a later negedge with the request dropped
    // and one idle cycle inserted so the ack flag has cleared.
    task automatic cache_op(input logic wr, input logic [5:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output int stall);
        bit ok = 0;
        cache_read      = ~wr;
        cache_write     = wr;
        cache_address   = a;
        cache_writedata = d;
        stall = 0;
        #1;
        for (int i = 0; i < 400; i++) begin
            if (!cache_busywait) begin
                ok = 1;
                break;
            end
            stall++;
            @(negedge CLK);
        end
        rd = cache_readdata;
        if (ok && wr) begin
            exp_q.push_back({a, d});
            shadow[a] = d;
        end
        cache_read  = 1'b0;
        cache_write = 1'b0;
        vectors++;
        if (!ok) begin
            $display("FAIL cache_op_timeout: addr=%h busywait=%b, required 0", a, cache_busywait);
            miscompares++;
        end
        @(negedge CLK);
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge CLK);
            if (wb_empty && !mem_write && !mem_read) done = 1;
        end
        vectors++;
        if (!done) begin
            $display("FAIL %s_drain: wb_count=%0d, required 0", name, wb_count);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cache_read      = 1'($urandom);
            cache_write     = 1'($urandom);
            cache_address   = 6'($urandom);
            cache_writedata = $urandom;
            @(negedge CLK);
            vectors++;
            if ({cache_busywait, mem_read, mem_write, wb_empty, wb_count} !== 7'b0001000 ||
                mem_address !== 6'h0 || mem_writedata !== 32'h0 || cache_readdata !== 32'h0) begin
                $display("FAIL reset_values: bw=%b rd=%b wr=%b empty=%b count=%0d addr=%h wd=%h cd=%h, required all 0 and empty=1",
                         cache_busywait, mem_read, mem_write, wb_empty, wb_count, mem_address, mem_writedata, cache_readdata);
                miscompares++;
            end
        end
        cache_read = 1'b0;
        cache_write = 1'b0;
        RESET = 1'b0;
        @(negedge CLK);
        vectors++;
        if (mem_read || mem_write || !wb_empty) begin
            $display("FAIL reset_release: mem_read=%b mem_write=%b wb_empty=%b, required 0 0 1", mem_read, mem_write, wb_empty);
            miscompares++;
        end
    endtask

    task automatic test_single_write();
        logic [31:0] rd;
        int stall;
        lat = 5;
        cache_op(1'b1, 6'h05, 32'hDEADBEEF, rd, stall);
        vectors++;
        if (stall != 1) begin
            $display("FAIL single_write_stall: %0d cycles, required 1", stall);
            miscompares++;
        end
        vectors++;
        if (mem_write !== 1'b1 || mem_address !== 6'h05 || mem_writedata !== 32'hDEADBEEF || wb_count !== 3'd1) begin
            $display("FAIL single_write_drain: wr=%b addr=%h data=%h count=%0d, required 1 05 deadbeef 1",
                     mem_write, mem_address, mem_writedata, wb_count);
            miscompares++;
        end
        wait_drain("single_write");
        vectors++;
        if (wb_empty !== 1'b1 || exp_q.size() != 0) begin
            $display("FAIL single_write_empty: wb_empty=%b pending=%0d, required 1 0", wb_empty, exp_q.size());
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int stall;
        hold = 1;
        lat = 1;
        ops_log.delete();
        fork
            begin
                for (int i = 1; i <= 5; i++) cache_op(1'b1, 6'(i), $urandom, rd, stall);
            end
            begin
                repeat (20) @(negedge CLK);
                vectors++;
                if (wb_count !== 3'd4 || cache_busywait !== 1'b1 || cache_write !== 1'b1 || cache_address !== 6'h05) begin
                    $display("FAIL back_to_back_full: count=%0d busywait=%b addr=%h, required 4 1 05",
                             wb_count, cache_busywait, cache_address);
                    miscompares++;
                end
                hold = 0;
            end
        join
        wait_drain("back_to_back");
        vectors++;
        if (ops_log.size() != 5 || ops_log[0] !== 7'h01 || ops_log[4] !== 7'h05) begin
            $display("FAIL back_to_back_order: %0d ops first=%h last=%h, required 5 01 05",
                     ops_log.size(), ops_log.size() > 0 ? ops_log[0] : 7'h7f, ops_log.size() > 0 ? ops_log[ops_log.size()-1] : 7'h7f);
            miscompares++;
        end
    endtask

    task automatic test_raw_forward();
        logic [31:0] rd;
        int stall;
        hold = 1;
        cache_op(1'b1, 6'h10, 32'hA, rd, stall);
        cache_op(1'b1, 6'h10, 32'hB, rd, stall);
        mem_read_seen = 0;
        cache_op(1'b0, 6'h10, 32'h0, rd, stall);
        vectors++;
        if (rd !== 32'hB || stall != 1) begin
            $display("FAIL raw_forward: data=%h stall=%0d, required 0000000b 1", rd, stall);
            miscompares++;
        end
        vectors++;
        if (mem_read_seen) begin
            $display("FAIL raw_no_mem_read: mem_read=1, required 0");
            miscompares++;
        end
        hold = 0;
        wait_drain("raw_forward");
    endtask

    task automatic test_read_priority();
        logic [31:0] rd;
        int stall;
        hold = 1;
        lat = 2;
        ops_log.delete();
        for (int i = 1; i <= 3; i++) cache_op(1'b1, 6'(i), $urandom, rd, stall);
        vectors++;
        if (mem_write !== 1'b1 || mem_address !== 6'h01) begin
            $display("FAIL read_prio_drain: mem_write=%b addr=%h, required 1 01", mem_write, mem_address);
            miscompares++;
        end
        fork
            cache_op(1'b0, 6'h20, 32'h0, rd, stall);
            begin
                repeat (4) @(negedge CLK);
                hold = 0;
            end
        join
        vectors++;
        if (rd !== shadow[6'h20]) begin
            $display("FAIL read_prio_data: got %h, required %h", rd, shadow[6'h20]);
            miscompares++;
        end
        wait_drain("read_priority");
        vectors++;
        if (ops_log.size() != 4 || ops_log[0] !== 7'h01 || ops_log[1] !== 7'h60 ||
            ops_log[2] !== 7'h02 || ops_log[3] !== 7'h03) begin
            $display("FAIL read_prio_order: %0d ops, required W01 R20 W02 W03", ops_log.size());
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] rd;
        int stall;
        bit wrote = 0;
        hold = 1;
        for (int i = 1; i <= 3; i++) cache_op(1'b1, 6'(8 + i), $urandom, rd, stall);
        vectors++;
        if (mem_write !== 1'b1 || wb_count !== 3'd3) begin
            $display("FAIL reset_mid_pre: mem_write=%b count=%0d, required 1 3", mem_write, wb_count);
            miscompares++;
        end
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        exp_q.delete();
        for (int a = 0; a < 64; a++) shadow[a] = mem_arr[a];
        vectors++;
        if (mem_write !== 1'b0 || wb_count !== 3'd0 || wb_empty !== 1'b1) begin
            $display("FAIL reset_mid_post: mem_write=%b count=%0d empty=%b, required 0 0 1", mem_write, wb_count, wb_empty);
            miscompares++;
        end
        hold = 0;
        repeat (20) begin
            @(negedge CLK);
            if (mem_write) wrote = 1;
        end
        vectors++;
        if (wrote) begin
            $display("FAIL reset_mid_quiet: mem_write=1 after reset, required 0");
            miscompares++;
        end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [5:0]  a;
        int stall;
        bit wr;
        for (int n = 0; n < 150; n++) begin
            lat = $urandom_range(0, 3);
            wr  = 1'($urandom);
            a   = 6'h30 + 6'($urandom_range(0, 7));
            cache_op(wr, a, $urandom, rd, stall);
            if (!wr) begin
                vectors++;
                if (rd !== shadow[a]) begin
                    $display("FAIL random_read: addr=%h got %h, required %h", a, rd, shadow[a]);
                    miscompares++;
                end
            end
        end
        wait_drain("random");
        vectors++;
        if (exp_q.size() != 0) begin
            $display("FAIL random_leftover: %0d writes not seen at memory, required 0", exp_q.size());
            miscompares++;
        end
    endtask

    initial begin
        for (int a = 0; a < 64; a++) begin
            mem_arr[a] = $urandom;
            shadow[a]  = mem_arr[a];
        end
        cache_read = 1'b0;
        cache_write = 1'b0;
        cache_address = '0;
        cache_writedata = '0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_raw_forward();
        test_read_priority();
        test_reset_mid_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcache_write_buffer.md
# dcache_write_buffer

Posted write buffer between the data cache's memory-side port and the data memory. Dirty-block writebacks from the cache are absorbed in one cycle and drained to memory in the background. Reads go to memory ahead of queued writes, except that a read whose block address matches a buffered write is answered from the buffer. On both sides the block uses the same level-held read/write plus busywait handshake that the data memory already presents.

## Interface
- DEPTH, 4, number of buffered block writes (power of 2, at least 2)
- ADDR_W, 6, block address width
- DATA_W, 32, block data width
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  synchronous reset, active-high; one clock, sampled on the rising edge of CLK
- cache_read  in  1  cache block-read request, held until busywait is seen low
- cache_write  in  1  cache block-write (writeback) request, held likewise
- cache_address  in  ADDR_W  request block address
- cache_writedata  in  DATA_W  writeback block data
- cache_readdata  out  DATA_W  read result, valid in the ack cycle
- cache_busywait  out  1  stall to the cache
- mem_read  out  1  read request to data memory (registered)
- mem_write  out  1  write request to data memory (registered)
- mem_address  out  ADDR_W  memory block address (registered)
- mem_writedata  out  DATA_W  memory write data (registered)
- mem_readdata  in  DATA_W  memory read data
- mem_busywait  in  1  memory busy; request completes on the edge where it is sampled low
- wb_empty  out  1  no buffered writes
- wb_count  out  $clog2(DEPTH)+1  number of buffered entries

## Operation
- Storage: circular FIFO of {address, data}, with head/tail pointers that wrap modulo DEPTH and a count register. Duplicate addresses are not coalesced.
- Ack: a registered one-cycle flag. cache_busywait = (cache_read | cache_write) & !ack, and is forced to 0 while RESET is high.
- Enqueue: on an edge with cache_write & !cache_read & !ack & count<DEPTH, write the entry at the tail and set ack. When full, busywait stays high until a pop frees a slot.
- Read hit: at cache_read & !ack, the address is compared against all valid entries. On a match, the youngest matching entry's data is loaded into cache_readdata and ack is set. Memory is not accessed.
- Read miss: the read is latched as pending. The memory FSM serves the pending read before any further drain.
- cache_read and cache_write both high: read is served and the write is ignored.
- Memory FSM states:
  - IDLE: if a read is pending, go to MREAD (mem_read=1, mem_address=cache_address). Else if count>0, go to DRAIN (mem_write=1, head address and data driven). Else stay in IDLE.
  - DRAIN: hold all memory outputs. On an edge with mem_busywait=0: pop the head, drop mem_write, return to IDLE.
  - MREAD: hold. On an edge with mem_busywait=0: capture mem_readdata into cache_readdata, set ack, drop mem_read, return to IDLE.
- Because every operation passes through IDLE, memory requests are separated by at least one deasserted cycle.
- An in-progress DRAIN is never aborted by a read; the read waits for it to finish.
- Simultaneous enqueue and pop on the same edge: count is unchanged. Legal when full, and the write is accepted.
- Forwarding compares against entries as they stood before the edge. An entry being popped on that same edge still forwards correctly.

## Timing
- Reset values: every output is 0 except wb_empty=1. State=IDLE, count=0, pointers=0, ack=0, pending read cleared.
- Reset mid-operation: at the RESET edge, all buffered writes and any pending read are discarded, and mem_read/mem_write are 0 after that edge.
- Write, not full: request present before edge E0; busywait low in the cycle after E0; the cache drops the request at E1. Latency is 1 cycle.
- Read hit: same 1-cycle latency; cache_readdata is valid in the cycle after E0.
- Read miss, FSM in IDLE: mem_read rises after E0. Ack comes 1 cycle after the edge where mem_busywait is sampled low.
- Drain: the first mem_write is asserted 1 cycle after enqueue if the FSM is in IDLE.
- wb_count/wb_empty update on the same edge as the push or pop.

## Test plan
- Reset: hold RESET for 2 edges with random inputs -> all outputs 0, wb_empty=1, no memory request is issued.
- Single write 6'h05 / 32'hDEADBEEF with a 5-cycle memory model -> cache_busywait high for exactly 1 cycle. Next cycle: mem_write=1, mem_address=6'h05, mem_writedata=32'hDEADBEEF. Entry pops when mem_busywait falls, and wb_empty returns to 1.
- Five back-to-back writes to 6'h01..6'h05 with memory busy -> wb_count peaks at 4 and write 5 stalls until the first pop completes. Memory sees addresses 01,02,03,04,05 in order.
- RAW forwarding: write 6'h10=32'hA, write 6'h10=32'hB, then read 6'h10 while memory is stalled -> cache_readdata=32'hB after 1 busywait cycle; mem_read never asserts.
- Read priority: three buffered writes to 6'h01..6'h03 and DRAIN of 6'h01 active; read 6'h20 arrives -> DRAIN of 6'h01 completes, then mem_read for 6'h20 returns memory data to the cache. Draining then resumes with 6'h02, 6'h03.
- Reset mid-DRAIN: assert RESET while mem_write=1 with count=3 -> after that edge mem_write=0, wb_count=0, wb_empty=1, and no further writes are issued.
